// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage MIPS pipeline.
// Latency: stall, pc_en, flush and new_pc are combinational in the request cycle; busy follows the FSM register.
// Backpressure: stall requests freeze the requesting stage and everything upstream; a redirect is held off while MEM is busy.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests (mem highest priority)
//   excp_valid, excp_eret  exception / ERET commit from MEM (eret qualifies valid)
//   cp0_epc, cp0_ebase, cp0_bev  CP0 state used to form the redirect target
//   stall[5:0]        per-stage freeze: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
//   pc_en             PC register enable (~stall[0])
//   flush, new_pc     one-cycle flush of all stage registers and PC redirect target
//   busy              sequencer is in PENDING or HOLD
//   perf_stall_cycles, perf_flush_count  only when PIPE_PERF_CNT_EN is defined
//
// Build option: define PIPE_PERF_CNT_EN to add the two 32-bit performance counters.

module pipeline_ctrl #(
  parameter logic [31:0] BEV_VECTOR = 32'hBFC00380,
  parameter logic [11:0] EXC_OFFSET = 12'h180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_eret,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_ebase,
  input  logic        cp0_bev,
  output logic [5:0]  stall,
  output logic        pc_en,
  output logic        flush,
  output logic [31:0] new_pc,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [5:0]  stall_enc;
  logic [31:0] target;

  // Priority stall encoding: a stalled stage also freezes every stage upstream of it.
  always_comb begin
    stall_enc = 6'b000000;
    if (stallreq_mem)      stall_enc = 6'b011111;
    else if (stallreq_ex)  stall_enc = 6'b001111;
    else if (stallreq_id)  stall_enc = 6'b000111;
    else if (stallreq_if)  stall_enc = 6'b000011;
  end

  // Redirect target. EBase page is the upper 20 bits; its low 12 bits are replaced by the offset.
  always_comb begin
    if (excp_eret)    target = cp0_epc;
    else if (cp0_bev) target = BEV_VECTOR;
    else              target = (cp0_ebase & 32'hFFFFF000) | {20'h0, EXC_OFFSET};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      S_IDLE: begin
        if (excp_valid) begin
          if (stallreq_mem) begin
            // MEM still owns an access: remember where to go and wait.
            state_d   = S_PENDING;
            pend_pc_d = target;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_PENDING: begin
        // excp_valid is ignored here; the first event already owns the redirect.
        if (!stallreq_mem) state_d = S_HOLD;
      end
      S_HOLD: begin
        // excp_valid seen now is the stale pre-flush value, so it is dropped.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    flush  = 1'b0;
    new_pc = '0;
    case (state_q)
      S_IDLE: begin
        if (excp_valid && !stallreq_mem) begin
          flush  = 1'b1;
          new_pc = target;
        end
      end
      S_PENDING: begin
        new_pc = pend_pc_q;
        if (!stallreq_mem) flush = 1'b1;
      end
      default: ;
    endcase
    // A reset cycle never issues a flush, whatever state is being left.
    if (rst) flush = 1'b0;
    // The flush cycle moves everything: no stage may be frozen while redirecting.
    stall = flush ? 6'b000000 : stall_enc;
    pc_en = ~stall[0];
    busy  = (state_q != S_IDLE);
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall[0] && !flush) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)              perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule
